// File: rtl/fx_issue_scheduler_pkg.sv
// Shared constants for the FX issue scheduler: unit code, default geometry, payload field layout.
package fx_issue_scheduler_pkg;

   localparam int FXUnitCode       = 0;
   localparam int FX_REG_WIDTH     = 5;
   localparam int FX_QUEUE_DEPTH   = 4;
   localparam int FX_PAYLOAD_WIDTH = 128;

   // Payload layout as decoded by the FX unit; the scheduler never looks inside these bits.
   localparam int PL_UNIT_LSB   = 0;
   localparam int PL_UNIT_WIDTH = 4;
   localparam int PL_OP_LSB     = 4;
   localparam int PL_OP_WIDTH   = 8;
   localparam int PL_IMM_LSB    = 12;
   localparam int PL_IMM_WIDTH  = 64;

   typedef enum logic [1:0] {
      CAND_NONE,
      CAND_QUEUE,
      CAND_DISPATCH
   } cand_src_e;

endpackage

// File: rtl/fx_scoreboard.sv
// GPR busy-bit scoreboard: set on issue, clear on writeback, set beats clear; flush clears all.
// FX_SCOREBOARD_BYPASS_EN lets a same-cycle writeback hide the busy bit from the lookups.
module fx_scoreboard
   import fx_issue_scheduler_pkg::*;
#(
   parameter int regWidth = FX_REG_WIDTH
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                flush,
   input  logic                set_vld,
   input  logic [regWidth-1:0] set_addr,
   input  logic                clr_vld,
   input  logic [regWidth-1:0] clr_addr,
   input  logic [regWidth-1:0] src1_addr,
   input  logic [regWidth-1:0] src2_addr,
   input  logic [regWidth-1:0] dst_addr,
   output logic                src1_busy,
   output logic                src2_busy,
   output logic                dst_busy
);
   localparam int NumRegs = 1 << regWidth;

   logic [NumRegs-1:0] busy;
   logic [NumRegs-1:0] set_mask;
   logic [NumRegs-1:0] clr_mask;
   logic [NumRegs-1:0] lookup;

   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (set_vld) set_mask[set_addr] = 1'b1;
      if (clr_vld) clr_mask[clr_addr] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     busy <= '0;
      else if (flush) busy <= '0;
      else            busy <= (busy & ~clr_mask) | set_mask;
   end

`ifdef FX_SCOREBOARD_BYPASS_EN
   assign lookup = busy & ~clr_mask;
`else
   assign lookup = busy;
`endif

   assign src1_busy = lookup[src1_addr];
   assign src2_busy = lookup[src2_addr];
   assign dst_busy  = lookup[dst_addr];

endmodule

// File: rtl/fx_issue_scheduler.sv
// In-order FX issue queue; issue pulse is registered, one cycle after dispatch into an empty queue.
// dispReady_o follows the registered occupancy only; option FX_SCOREBOARD_BYPASS_EN (writeback bypass).
module fx_issue_scheduler
   import fx_issue_scheduler_pkg::*;
#(
   parameter int regWidth     = FX_REG_WIDTH,
   parameter int queueDepth   = FX_QUEUE_DEPTH,
   parameter int payloadWidth = FX_PAYLOAD_WIDTH
) (
   input  logic                        clock_i,
   input  logic                        reset_ni,
   input  logic                        dispValid_i,
   output logic                        dispReady_o,
   input  logic [regWidth-1:0]         dispSrc1Addr_i,
   input  logic [regWidth-1:0]         dispSrc2Addr_i,
   input  logic [regWidth-1:0]         dispDstAddr_i,
   input  logic                        dispSrc1En_i,
   input  logic                        dispSrc2En_i,
   input  logic                        dispDstEn_i,
   input  logic [payloadWidth-1:0]     dispPayload_i,
   output logic                        issueValid_o,
   output logic [payloadWidth-1:0]     issuePayload_o,
   output logic [regWidth-1:0]         issueDstAddr_o,
   output logic                        issueDstEn_o,
   input  logic                        wbValid_i,
   input  logic [regWidth-1:0]         wbAddr_i,
   input  logic                        flush_i,
   output logic [$clog2(queueDepth):0] occupancy_o
);
   localparam int PtrW = $clog2(queueDepth);
   localparam int CntW = PtrW + 1;

   logic [payloadWidth-1:0] q_payload [queueDepth];
   logic [regWidth-1:0]     q_src1    [queueDepth];
   logic [regWidth-1:0]     q_src2    [queueDepth];
   logic [regWidth-1:0]     q_dst     [queueDepth];
   logic [queueDepth-1:0]   q_src1_en, q_src2_en, q_dst_en;
   logic [PtrW-1:0]         wr_ptr, rd_ptr;
   logic [CntW-1:0]         count;

   cand_src_e               cand_src;
   logic [payloadWidth-1:0] cand_payload;
   logic [regWidth-1:0]     cand_src1, cand_src2, cand_dst;
   logic                    cand_src1_en, cand_src2_en, cand_dst_en;
   logic                    src1_busy, src2_busy, dst_busy;
   logic                    disp_fire, can_issue, push, pop;

   assign dispReady_o = (count < CntW'(queueDepth));
   assign occupancy_o = count;
   assign disp_fire   = dispValid_i && dispReady_o && !flush_i;

   // The head is the oldest queued entry; an empty queue lets the arriving instruction be the head.
   always_comb begin
      cand_src     = CAND_NONE;
      cand_payload = dispPayload_i;
      cand_src1    = dispSrc1Addr_i;
      cand_src2    = dispSrc2Addr_i;
      cand_dst     = dispDstAddr_i;
      cand_src1_en = dispSrc1En_i;
      cand_src2_en = dispSrc2En_i;
      cand_dst_en  = dispDstEn_i;
      if (count != '0) begin
         cand_src     = CAND_QUEUE;
         cand_payload = q_payload[rd_ptr];
         cand_src1    = q_src1[rd_ptr];
         cand_src2    = q_src2[rd_ptr];
         cand_dst     = q_dst[rd_ptr];
         cand_src1_en = q_src1_en[rd_ptr];
         cand_src2_en = q_src2_en[rd_ptr];
         cand_dst_en  = q_dst_en[rd_ptr];
      end else if (disp_fire) begin
         cand_src = CAND_DISPATCH;
      end
   end

   fx_scoreboard #(.regWidth(regWidth)) u_sb (
      .clk       (clock_i),
      .rst_n     (reset_ni),
      .flush     (flush_i),
      .set_vld   (can_issue && cand_dst_en),
      .set_addr  (cand_dst),
      .clr_vld   (wbValid_i),
      .clr_addr  (wbAddr_i),
      .src1_addr (cand_src1),
      .src2_addr (cand_src2),
      .dst_addr  (cand_dst),
      .src1_busy (src1_busy),
      .src2_busy (src2_busy),
      .dst_busy  (dst_busy)
   );

   assign can_issue = (cand_src != CAND_NONE) && !flush_i
                      && !(cand_src1_en && src1_busy)
                      && !(cand_src2_en && src2_busy)
                      && !(cand_dst_en  && dst_busy);
   assign pop  = can_issue && (cand_src == CAND_QUEUE);
   assign push = disp_fire && !(can_issue && (cand_src == CAND_DISPATCH));

   always_ff @(posedge clock_i) begin
      if (push) begin
         q_payload[wr_ptr] <= dispPayload_i;
         q_src1[wr_ptr]    <= dispSrc1Addr_i;
         q_src2[wr_ptr]    <= dispSrc2Addr_i;
         q_dst[wr_ptr]     <= dispDstAddr_i;
         q_src1_en[wr_ptr] <= dispSrc1En_i;
         q_src2_en[wr_ptr] <= dispSrc2En_i;
         q_dst_en[wr_ptr]  <= dispDstEn_i;
      end
   end

   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CntW'(push) - CntW'(pop);
      end
   end

   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         issueValid_o   <= 1'b0;
         issuePayload_o <= '0;
         issueDstAddr_o <= '0;
         issueDstEn_o   <= 1'b0;
      end else begin
         issueValid_o <= can_issue;
         if (can_issue) begin
            issuePayload_o <= cand_payload;
            issueDstAddr_o <= cand_dst;
            issueDstEn_o   <= cand_dst_en;
         end
      end
   end

endmodule

// File: tb/tb_fx_issue_scheduler.sv
// Bench for fx_issue_scheduler: directed scenarios and random traffic against a queue-level model.
module tb_fx_issue_scheduler;
   localparam int RW   = 5;
   localparam int QD   = 4;
   localparam int PW   = 128;
   localparam int NREG = 32;
   localparam int OW   = $clog2(QD) + 1;

   typedef struct packed {
      logic [PW-1:0] pl;
      logic [RW-1:0] s1;
      logic [RW-1:0] s2;
      logic [RW-1:0] d;
      logic          e1;
      logic          e2;
      logic          ed;
   } ins_t;

   logic          clock_i = 1'b0;
   logic          reset_ni = 1'b1;
   logic          dispValid_i = 1'b0;
   logic          dispReady_o;
   logic [RW-1:0] dispSrc1Addr_i = '0, dispSrc2Addr_i = '0, dispDstAddr_i = '0;
   logic          dispSrc1En_i = 1'b0, dispSrc2En_i = 1'b0, dispDstEn_i = 1'b0;
   logic [PW-1:0] dispPayload_i = '0;
   logic          issueValid_o;
   logic [PW-1:0] issuePayload_o;
   logic [RW-1:0] issueDstAddr_o;
   logic          issueDstEn_o;
   logic          wbValid_i = 1'b0;
   logic [RW-1:0] wbAddr_i = '0;
   logic          flush_i = 1'b0;
   logic [OW-1:0] occupancy_o;

   fx_issue_scheduler #(.regWidth(RW), .queueDepth(QD), .payloadWidth(PW)) dut (
      .clock_i(clock_i), .reset_ni(reset_ni),
      .dispValid_i(dispValid_i), .dispReady_o(dispReady_o),
      .dispSrc1Addr_i(dispSrc1Addr_i), .dispSrc2Addr_i(dispSrc2Addr_i), .dispDstAddr_i(dispDstAddr_i),
      .dispSrc1En_i(dispSrc1En_i), .dispSrc2En_i(dispSrc2En_i), .dispDstEn_i(dispDstEn_i),
      .dispPayload_i(dispPayload_i),
      .issueValid_o(issueValid_o), .issuePayload_o(issuePayload_o),
      .issueDstAddr_o(issueDstAddr_o), .issueDstEn_o(issueDstEn_o),
      .wbValid_i(wbValid_i), .wbAddr_i(wbAddr_i), .flush_i(flush_i),
      .occupancy_o(occupancy_o)
   );

   always #5 clock_i = ~clock_i;

   // Reference model: pending instructions in program order plus a set of busy registers.
   ins_t            mq[$];
   logic [NREG-1:0] mbusy;
   logic            exp_vld;
   logic [PW-1:0]   exp_pl;
   logic [RW-1:0]   exp_dst;
   logic            exp_den;
   int              n_pass = 0;
   int              n_total = 0;

   function automatic ins_t mk(input logic [RW-1:0] s1, input logic e1, input logic [RW-1:0] s2,
                               input logic e2, input logic [RW-1:0] d, input logic ed);
      ins_t i;
      i.pl = {$urandom(), $urandom(), $urandom(), $urandom()};
      i.s1 = s1; i.e1 = e1; i.s2 = s2; i.e2 = e2; i.d = d; i.ed = ed;
      return i;
   endfunction

   function automatic ins_t cur_ins();
      ins_t i;
      i.pl = dispPayload_i; i.s1 = dispSrc1Addr_i; i.s2 = dispSrc2Addr_i; i.d = dispDstAddr_i;
      i.e1 = dispSrc1En_i; i.e2 = dispSrc2En_i; i.ed = dispDstEn_i;
      return i;
   endfunction

   task automatic drive(input logic v, input ins_t i);
      dispValid_i = v;
      dispPayload_i = i.pl;
      dispSrc1Addr_i = i.s1; dispSrc2Addr_i = i.s2; dispDstAddr_i = i.d;
      dispSrc1En_i = i.e1; dispSrc2En_i = i.e2; dispDstEn_i = i.ed;
   endtask

   task automatic idle();
      dispValid_i = 1'b0;
      wbValid_i = 1'b0;
      flush_i = 1'b0;
   endtask

   task automatic model_reset();
      mq.delete();
      mbusy = '0;
      exp_vld = 1'b0; exp_pl = '0; exp_dst = '0; exp_den = 1'b0;
   endtask

   // Advance the model by one cycle using the inputs currently driven, then clock the DUT.
   task automatic tick();
      ins_t            pend[$];
      ins_t            h;
      logic [NREG-1:0] view;
      if (flush_i) begin
         mq.delete();
         mbusy = '0;
         exp_vld = 1'b0;
      end else begin
         pend = mq;
         if (dispValid_i && mq.size() < QD) pend.push_back(cur_ins());
         view = mbusy;
`ifdef FX_SCOREBOARD_BYPASS_EN
         if (wbValid_i) view[wbAddr_i] = 1'b0;
`endif
         exp_vld = 1'b0;
         if (pend.size() > 0) begin
            h = pend[0];
            if (!(h.e1 && view[h.s1]) && !(h.e2 && view[h.s2]) && !(h.ed && view[h.d])) begin
               exp_vld = 1'b1; exp_pl = h.pl; exp_dst = h.d; exp_den = h.ed;
               pend.delete(0);
            end
         end
         if (wbValid_i) mbusy[wbAddr_i] = 1'b0;
         if (exp_vld && exp_den) mbusy[exp_dst] = 1'b1;
         mq = pend;
      end
      @(posedge clock_i);
      #1;
   endtask

   task automatic test_reset();
      idle();
      #2 reset_ni = 1'b0;
      model_reset();
      #21;
      n_total++;
      if (issueValid_o !== 1'b0) $display("FAIL rst_valid: got %0b want 0", issueValid_o); else n_pass++;
      n_total++;
      if (occupancy_o !== '0) $display("FAIL rst_occ: got %0d want 0", occupancy_o); else n_pass++;
      n_total++;
      if (issuePayload_o !== '0 || issueDstAddr_o !== '0 || issueDstEn_o !== 1'b0)
         $display("FAIL rst_outs: payload %h dst %0d den %0b want zeros", issuePayload_o, issueDstAddr_o, issueDstEn_o);
      else n_pass++;
      n_total++;
      if (dut.u_sb.busy !== '0) $display("FAIL rst_busy: got %h want 0", dut.u_sb.busy); else n_pass++;
      reset_ni = 1'b1;
      #2;
      n_total++;
      if (dispReady_o !== 1'b1) $display("FAIL rst_ready: got %0b want 1", dispReady_o); else n_pass++;
      @(posedge clock_i);
      #1;
   endtask

   task automatic test_first_issue();
      ins_t a;
      a = mk(5'd3, 1'b1, 5'd4, 1'b1, 5'd5, 1'b1);
      drive(1'b1, a);
      tick();
      idle();
      n_total++;
      if (issueValid_o !== 1'b1) $display("FAIL first_valid: got %0b want 1", issueValid_o); else n_pass++;
      n_total++;
      if (issueDstAddr_o !== 5'd5 || issueDstEn_o !== 1'b1)
         $display("FAIL first_dst: got %0d/%0b want 5/1", issueDstAddr_o, issueDstEn_o);
      else n_pass++;
      n_total++;
      if (issuePayload_o !== a.pl) $display("FAIL first_payload: got %h want %h", issuePayload_o, a.pl); else n_pass++;
      n_total++;
      if (dut.u_sb.busy[5] !== 1'b1) $display("FAIL first_busy5: got %0b want 1", dut.u_sb.busy[5]); else n_pass++;
   endtask

   task automatic test_raw_stall();
      ins_t b;
      b = mk(5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1);
      drive(1'b1, b);
      tick();
      idle();
      n_total++;
      if (issueValid_o !== 1'b0 || occupancy_o !== OW'(1))
         $display("FAIL raw_stall: valid %0b occ %0d want 0/1", issueValid_o, occupancy_o);
      else n_pass++;
      tick();
      tick();
      n_total++;
      if (issueValid_o !== 1'b0) $display("FAIL raw_hold: got %0b want 0", issueValid_o); else n_pass++;
      wbValid_i = 1'b1; wbAddr_i = 5'd5;
      tick();
      wbValid_i = 1'b0;
`ifdef FX_SCOREBOARD_BYPASS_EN
      n_total++;
      if (issueValid_o !== 1'b1 || issuePayload_o !== b.pl)
         $display("FAIL raw_wake: valid %0b payload %h want 1/%h", issueValid_o, issuePayload_o, b.pl);
      else n_pass++;
`else
      n_total++;
      if (issueValid_o !== 1'b0) $display("FAIL raw_early: got %0b want 0 in writeback cycle", issueValid_o); else n_pass++;
      tick();
      n_total++;
      if (issueValid_o !== 1'b1 || issuePayload_o !== b.pl)
         $display("FAIL raw_wake: valid %0b payload %h want 1/%h", issueValid_o, issuePayload_o, b.pl);
      else n_pass++;
`endif
      wbValid_i = 1'b1; wbAddr_i = 5'd6;
      tick();
      wbValid_i = 1'b0;
      n_total++;
      if (issueValid_o !== 1'b0) $display("FAIL raw_pulse: got %0b want 0", issueValid_o); else n_pass++;
   endtask

   task automatic test_back_to_back();
      ins_t ins[5];
      int   accepted = 0, issued = 0;
      logic go;
      for (int k = 0; k < 5; k++) ins[k] = mk(5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
      drive(1'b1, mk(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1));
      tick();
      for (int cyc = 0; cyc < 40 && issued < 5; cyc++) begin
         if (accepted < 5) drive(1'b1, ins[accepted]); else dispValid_i = 1'b0;
         wbValid_i = (cyc == 8); wbAddr_i = 5'd7;
         n_total++;
         if (dispReady_o !== (mq.size() < QD))
            $display("FAIL b2b_ready cyc %0d: got %0b want %0b", cyc, dispReady_o, mq.size() < QD);
         else n_pass++;
         if (cyc == 6) begin
            n_total++;
            if (dispReady_o !== 1'b0 || occupancy_o !== OW'(4) || accepted != 4)
               $display("FAIL b2b_full: ready %0b occ %0d accepted %0d want 0/4/4", dispReady_o, occupancy_o, accepted);
            else n_pass++;
         end
         go = dispValid_i && dispReady_o;
         if (go && accepted == 4) begin
            n_total++;
            if (issued < 1) $display("FAIL b2b_fifth: accepted before any issue (issued %0d want >=1)", issued);
            else n_pass++;
         end
         tick();
         if (go) accepted++;
         if (issueValid_o) begin
            n_total++;
            if (issued >= 5) $display("FAIL b2b_extra: issue %0d beyond 5 dispatched", issued);
            else if (issuePayload_o !== ins[issued].pl)
               $display("FAIL b2b_order %0d: got %h want %h", issued, issuePayload_o, ins[issued].pl);
            else n_pass++;
            issued++;
         end
      end
      idle();
      n_total++;
      if (accepted != 5 || issued != 5) $display("FAIL b2b_done: accepted %0d issued %0d want 5/5", accepted, issued);
      else n_pass++;
   endtask

   task automatic test_wrap();
      ins_t          ins[10];
      logic [PW-1:0] exp_q[$];
      logic [PW-1:0] want;
      int            k = 0, got = 0;
      logic          offer, go;
      for (int i = 0; i < 10; i++) ins[i] = mk(5'd12, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
      drive(1'b1, mk(5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1));
      tick();
      for (int cyc = 0; cyc < 100 && got < 10; cyc++) begin
         offer = (k < 10) && ($urandom_range(0, 9) < 8);
         drive(offer, ins[(k < 10) ? k : 9]);
         wbValid_i = (cyc == 6); wbAddr_i = 5'd12;
         go = offer && dispReady_o;
         tick();
         if (go) begin exp_q.push_back(ins[k].pl); k++; end
         if (issueValid_o) begin
            n_total++;
            if (exp_q.size() == 0) $display("FAIL wrap_dup: unexpected issue %h", issuePayload_o);
            else begin
               want = exp_q.pop_front();
               if (issuePayload_o !== want) $display("FAIL wrap_order %0d: got %h want %h", got, issuePayload_o, want);
               else n_pass++;
            end
            got++;
         end
      end
      idle();
      n_total++;
      if (got != 10 || k != 10) $display("FAIL wrap_count: issued %0d accepted %0d want 10/10", got, k);
      else n_pass++;
   endtask

   task automatic test_flush();
      drive(1'b1, mk(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1));
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, mk(5'd9, 1'b1, 5'd1, 1'b0, 5'd2, 1'b0));
         tick();
      end
      idle();
      n_total++;
      if (occupancy_o !== OW'(3) || dut.u_sb.busy[9] !== 1'b1)
         $display("FAIL flush_setup: occ %0d busy9 %0b want 3/1", occupancy_o, dut.u_sb.busy[9]);
      else n_pass++;
      flush_i = 1'b1;
      drive(1'b1, mk(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0));
      tick();
      idle();
      n_total++;
      if (occupancy_o !== '0 || dut.u_sb.busy[9] !== 1'b0 || issueValid_o !== 1'b0)
         $display("FAIL flush_clear: occ %0d busy9 %0b valid %0b want 0/0/0", occupancy_o, dut.u_sb.busy[9], issueValid_o);
      else n_pass++;
      flush_i = 1'b1;
      drive(1'b1, mk(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0));
      tick();
      idle();
      n_total++;
      if (issueValid_o !== 1'b0 || occupancy_o !== '0)
         $display("FAIL flush_override: valid %0b occ %0d want 0/0", issueValid_o, occupancy_o);
      else n_pass++;
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         drive($urandom_range(0, 9) < 6,
               mk(RW'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), RW'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), RW'($urandom_range(0, 7)), 1'($urandom_range(0, 1))));
         wbValid_i = ($urandom_range(0, 9) < 4);
         wbAddr_i  = RW'($urandom_range(0, 7));
         flush_i   = ($urandom_range(0, 49) == 0);
         n_total++;
         if (dispReady_o !== (mq.size() < QD))
            $display("FAIL rnd_ready cyc %0d: got %0b want %0b", c, dispReady_o, mq.size() < QD);
         else n_pass++;
         tick();
         n_total++;
         if (issueValid_o !== exp_vld) $display("FAIL rnd_valid cyc %0d: got %0b want %0b", c, issueValid_o, exp_vld);
         else n_pass++;
         n_total++;
         if (issuePayload_o !== exp_pl || issueDstAddr_o !== exp_dst || issueDstEn_o !== exp_den)
            $display("FAIL rnd_outs cyc %0d: payload %h dst %0d den %0b want %h/%0d/%0b",
                     c, issuePayload_o, issueDstAddr_o, issueDstEn_o, exp_pl, exp_dst, exp_den);
         else n_pass++;
         n_total++;
         if (occupancy_o !== OW'(mq.size())) $display("FAIL rnd_occ cyc %0d: got %0d want %0d", c, occupancy_o, mq.size());
         else n_pass++;
         n_total++;
         if (dut.u_sb.busy !== mbusy) $display("FAIL rnd_busy cyc %0d: got %h want %h", c, dut.u_sb.busy, mbusy);
         else n_pass++;
      end
      idle();
      flush_i = 1'b1;
      tick();
      idle();
   endtask

   task automatic test_async_reset();
      ins_t n;
      drive(1'b1, mk(5'd0, 1'b0, 5'd0, 1'b0, 5'd11, 1'b1));
      tick();
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, mk(5'd11, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0));
         tick();
      end
      idle();
      n_total++;
      if (occupancy_o !== OW'(4) || dispReady_o !== 1'b0)
         $display("FAIL areset_setup: occ %0d ready %0b want 4/0", occupancy_o, dispReady_o);
      else n_pass++;
      #3 reset_ni = 1'b0;
      #1;
      model_reset();
      n_total++;
      if (occupancy_o !== '0 || dispReady_o !== 1'b1 || issueValid_o !== 1'b0)
         $display("FAIL areset_queue: occ %0d ready %0b valid %0b want 0/1/0", occupancy_o, dispReady_o, issueValid_o);
      else n_pass++;
      n_total++;
      if (issuePayload_o !== '0 || issueDstAddr_o !== '0 || issueDstEn_o !== 1'b0 || dut.u_sb.busy !== '0)
         $display("FAIL areset_outs: payload %h dst %0d den %0b busy %h want zeros",
                  issuePayload_o, issueDstAddr_o, issueDstEn_o, dut.u_sb.busy);
      else n_pass++;
      #10 reset_ni = 1'b1;
      n = mk(5'd11, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1);
      drive(1'b1, n);
      tick();
      idle();
      n_total++;
      if (issueValid_o !== 1'b1 || issuePayload_o !== n.pl || issueDstAddr_o !== 5'd3)
         $display("FAIL areset_after: valid %0b payload %h dst %0d want 1/%h/3", issueValid_o, issuePayload_o, issueDstAddr_o, n.pl);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_first_issue();
      test_raw_stall();
      test_back_to_back();
      test_wrap();
      test_flush();
      test_random();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
